// File: rtl/cnn_uart_pkg.sv
// Shared types and widths for the CNN result UART transmitter.
package cnn_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int BAUD_CNT_W = 12;

endpackage

// File: rtl/cnn_tx_fifo.sv
// Byte FIFO between cnn_core pushes and the UART frame engine.
module cnn_tx_fifo
    import cnn_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [PW:0]          cnt_q;
    logic                 do_push;
    logic                 do_pop;

    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cnn_uart_tx.sv
// UART 8N1 transmitter for CNN result bytes; tx_done marks each finished frame.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for BAUD_DIV cycles
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); tx_done on its last cycle
module cnn_uart_tx
    import cnn_uart_pkg::*;
#(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       busy,
    output logic       full,
    output logic       ovf
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_LOAD = BAUD_CNT_W'(BAUD_DIV - 1);

    tx_state_t             state_q, state_d;
    logic [BAUD_CNT_W-1:0] baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  ovf_q;
    logic                  pop;
    logic                  baud_tc;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_BITS-1:0]  fifo_dout;

    cnn_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (trmt),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_tc = (baud_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_q | (trmt & fifo_full & ~pop);
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = BAUD_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tc) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_tc) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_tc) begin
                    // Chain straight into the next start bit when more bytes are queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        baud_d  = BAUD_LOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        tx_done = (state_q == STOP) && baud_tc;
        busy    = (state_q != IDLE) || !fifo_empty;
    end

    assign TX   = tx_q;
    assign full = fifo_full;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cnn_uart_tx.sv
// Directed bench for cnn_uart_tx: one instance at BAUD_DIV=4, one at defaults.
module tb_cnn_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       trmt;
    logic       sel;
    logic [7:0] tx_data;
    logic       trmt_a, tx_a, done_a, busy_a, full_a, ovf_a;
    logic       trmt_b, tx_b, done_b, busy_b, full_b, ovf_b;
    logic       tx_m, done_m;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    int         last_fall = 0;

    assign trmt_a = trmt & ~sel;
    assign trmt_b = trmt & sel;
    assign tx_m   = sel ? tx_b : tx_a;
    assign done_m = sel ? done_b : done_a;

    cnn_uart_tx #(.BAUD_DIV(4), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .trmt(trmt_a), .tx_data(tx_data),
        .TX(tx_a), .tx_done(done_a), .busy(busy_a), .full(full_a), .ovf(ovf_a)
    );

    cnn_uart_tx u_dut_def (
        .clk(clk), .rst(rst), .trmt(trmt_b), .tx_data(tx_data),
        .TX(tx_b), .tx_done(done_b), .busy(busy_b), .full(full_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_one(input logic [7:0] b);
        trmt    = 1'b1;
        tx_data = b;
        @(negedge clk);
        trmt    = 1'b0;
    endtask

    // Waits for a start bit, then samples one full frame (10*div cycles) at negedges.
    task automatic capture(input int div, output bit found, output int gap,
                           output logic [9:0] bits, output bit stable,
                           output int dcnt, output int dpos);
        found  = 1'b0;
        gap    = 0;
        stable = 1'b1;
        dcnt   = 0;
        dpos   = 0;
        bits   = '1;
        @(negedge clk);
        while (tx_m !== 1'b0 && gap < 20*div + 20) begin
            @(negedge clk);
            gap++;
        end
        if (tx_m === 1'b0) begin
            found     = 1'b1;
            last_fall = cyc;
            for (int i = 0; i < 10*div; i++) begin
                if (i > 0) @(negedge clk);
                if (i % div == 0) bits[i/div] = tx_m;
                else if (tx_m !== bits[i/div]) stable = 1'b0;
                if (done_m === 1'b1) begin
                    dcnt++;
                    dpos = i + 1;
                end
            end
        end
    endtask

    task automatic frame_chk(input string tag, input logic [7:0] exp, input int div, input bit contig);
        bit         found, stable;
        int         gap, dcnt, dpos;
        logic [9:0] bits;
        capture(div, found, gap, bits, stable, dcnt, dpos);
        chk({tag, ".found"}, found, 1);
        chk({tag, ".bits"}, bits, {1'b1, exp, 1'b0});
        chk({tag, ".bit_len"}, stable, 1);
        chk({tag, ".done_cnt"}, dcnt, 1);
        chk({tag, ".done_pos"}, dpos, 10*div);
        if (contig) chk({tag, ".gap"}, gap, 0);
    endtask

    task automatic no_frame_chk(input string tag);
        bit         found, stable;
        int         gap, dcnt, dpos;
        logic [9:0] bits;
        capture(4, found, gap, bits, stable, dcnt, dpos);
        chk(tag, found, 0);
    endtask

    initial begin
        int t0;
        int n;
        int bad;
        rst     = 1'b1;
        trmt    = 1'b0;
        tx_data = 8'h00;
        sel     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.tx", tx_a, 1);
        chk("reset.tx_done", done_a, 0);
        chk("reset.busy", busy_a, 0);
        chk("reset.full", full_a, 0);
        chk("reset.ovf", ovf_a, 0);
        chk("reset.tx_def", tx_b, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: frame 0,1,0,1,0,0,1,0,1,1 for 0xA5
        t0 = cyc;
        fork
            push_one(8'hA5);
            begin
                bit         found, stable;
                int         gap, dcnt, dpos;
                logic [9:0] bits;
                capture(4, found, gap, bits, stable, dcnt, dpos);
                chk("single.found", found, 1);
                chk("single.bits", bits, 10'b1_1010_0101_0);
                chk("single.bit_len", stable, 1);
                chk("single.done_cnt", dcnt, 1);
                chk("single.done_pos", dpos, 40);
            end
        join
        chk("single.latency", last_fall - t0, 2);
        repeat (3) @(negedge clk);
        chk("single.idle_busy", busy_a, 0);
        chk("single.idle_tx", tx_a, 1);

        // Back-to-back frames
        fork
            begin push_one(8'h01); push_one(8'h80); push_one(8'hFF); end
            begin
                frame_chk("b2b0", 8'h01, 4, 0);
                frame_chk("b2b1", 8'h80, 4, 1);
                frame_chk("b2b2", 8'hFF, 4, 1);
            end
        join
        chk("b2b.busy_last", busy_a, 1);
        @(negedge clk);
        chk("b2b.busy_after", busy_a, 0);
        chk("b2b.tx_after", tx_a, 1);

        // Full FIFO plus push on the tx_done cycle: 1 in flight + 4 queued + 1 = 6 frames
        fork
            begin
                push_one(8'h10); push_one(8'h21); push_one(8'h32);
                push_one(8'h43); push_one(8'h54);
                chk("fwp.full", full_a, 1);
                n = 0;
                while (done_a !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("fwp.done_seen", done_a, 1);
                push_one(8'h65);
                chk("fwp.ovf", ovf_a, 0);
                chk("fwp.full_kept", full_a, 1);
            end
            begin
                frame_chk("fwp0", 8'h10, 4, 0);
                frame_chk("fwp1", 8'h21, 4, 1);
                frame_chk("fwp2", 8'h32, 4, 1);
                frame_chk("fwp3", 8'h43, 4, 1);
                frame_chk("fwp4", 8'h54, 4, 1);
                frame_chk("fwp5", 8'h65, 4, 1);
            end
        join
        no_frame_chk("fwp.no_extra");
        chk("fwp.ovf_end", ovf_a, 0);

        // Overflow: six pushes, sixth is dropped
        fork
            begin
                push_one(8'h81); push_one(8'h92); push_one(8'hA3);
                push_one(8'hB4); push_one(8'hC5); push_one(8'hD6);
                chk("ovf.ovf", ovf_a, 1);
                chk("ovf.full", full_a, 1);
            end
            begin
                frame_chk("ovf0", 8'h81, 4, 0);
                frame_chk("ovf1", 8'h92, 4, 1);
                frame_chk("ovf2", 8'hA3, 4, 1);
                frame_chk("ovf3", 8'hB4, 4, 1);
                frame_chk("ovf4", 8'hC5, 4, 1);
            end
        join
        no_frame_chk("ovf.no_sixth");
        chk("ovf.sticky", ovf_a, 1);

        // Reset during data bit 3 of 0xC3 (bit 3 = 0) with a second byte queued
        push_one(8'hC3);
        push_one(8'h99);
        n = 0;
        while (tx_a !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (17) @(negedge clk);
        chk("rst.pre_tx", tx_a, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst.tx", tx_a, 1);
        chk("rst.tx_done", done_a, 0);
        chk("rst.busy", busy_a, 0);
        chk("rst.full", full_a, 0);
        chk("rst.ovf", ovf_a, 0);
        trmt    = 1'b1;
        tx_data = 8'hEE;
        repeat (3) @(negedge clk);
        trmt = 1'b0;
        rst  = 1'b0;
        bad  = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        chk("rst.quiet", bad, 0);
        fork
            push_one(8'h3C);
            frame_chk("rst.clean", 8'h3C, 4, 0);
        join

        // Default parameters: 434 cycles per bit, 4340 per frame
        sel = 1'b1;
        @(negedge clk);
        fork
            push_one(8'h55);
            frame_chk("def", 8'h55, 434, 0);
        join
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
